// File: rtl/vga_rect_plotter_pkg.sv
// vga_rect_plotter_pkg
//  Shared definitions for the VGA pixel engines: coordinate/colour widths,
//  screen geometry, mode and state encodings, and the outline edge test.
//  Future line and character engines import the same package.
package vga_rect_plotter_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Screen limits at extent width (one bit wider than a coordinate).
    localparam logic [X_W:0] SCREEN_XE = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] SCREEN_YE = SCREEN_H[Y_W:0];

    typedef enum logic [1:0] {
        MODE_FILL     = 2'd0,
        MODE_OUTLINE  = 2'd1,
        MODE_CLEAR    = 2'd2,
        MODE_FILL_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    // Decides whether the walked coordinate is written. Outline compares
    // against the unclipped last column/row, so an edge pushed off-screen
    // by clipping is simply never reached.
    function automatic logic pixel_plot(
        input mode_e          m,
        input logic [X_W-1:0] px,
        input logic [Y_W-1:0] py,
        input logic [X_W-1:0] left,
        input logic [Y_W-1:0] top,
        input logic [X_W:0]   right,
        input logic [Y_W:0]   bottom
    );
        if (m != MODE_OUTLINE) begin
            return 1'b1;
        end
        return (px == left) || (py == top) ||
               ({1'b0, px} == right) || ({1'b0, py} == bottom);
    endfunction

endpackage

// File: rtl/vga_rect_plotter_if.sv
// vga_rect_plotter_if
//  Request/handshake and pixel-port bundle between user logic and the
//  rectangle plotter.
//  master: user side  - drives start/mode/x0/y0/w/h/color,
//                       sees busy/done and the VGA pixel port.
//  slave : plotter    - the reverse.
interface vga_rect_plotter_if;
    import vga_rect_plotter_pkg::*;

    logic           start;
    logic [1:0]     mode;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic [C_W-1:0] color;
    logic           busy;
    logic           done;
    logic [X_W-1:0] VGA_X;
    logic [Y_W-1:0] VGA_Y;
    logic [C_W-1:0] VGA_COLOR;
    logic           plot;

    modport master (
        output start, mode, x0, y0, w, h, color,
        input  busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );

    modport slave (
        input  start, mode, x0, y0, w, h, color,
        output busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );

endinterface

// File: rtl/vga_rect_plotter_clip.sv
// vga_rect_clip (combinational)
//  Maps a request (mode, x0, y0, w, h) to the walked area:
//   xs, ys : first column/row
//   xe, ye : exclusive end column/row, clamped to the screen
//   empty  : nothing to walk
//  Clear mode ignores the rectangle and covers the whole screen.
module vga_rect_clip
    import vga_rect_plotter_pkg::*;
(
    input  mode_e          mode,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] xs,
    output logic [Y_W-1:0] ys,
    output logic [X_W:0]   xe,
    output logic [Y_W:0]   ye,
    output logic           empty
);

    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    // Sums are one bit wider than the operands so x0+w never wraps
    // before it is clamped to the screen edge.
    always_comb begin
        x_sum = {1'b0, x0} + {1'b0, w};
        y_sum = {1'b0, y0} + {1'b0, h};
        xs    = x0;
        ys    = y0;
        xe    = (x_sum > SCREEN_XE) ? SCREEN_XE : x_sum;
        ye    = (y_sum > SCREEN_YE) ? SCREEN_YE : y_sum;
        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= SCREEN_XE) || ({1'b0, y0} >= SCREEN_YE);
        if (mode == MODE_CLEAR) begin
            xs    = '0;
            ys    = '0;
            xe    = SCREEN_XE;
            ye    = SCREEN_YE;
            empty = 1'b0;
        end
    end

endmodule

// File: rtl/vga_rect_plotter.sv
// vga_rect_plotter
//  Pixel engine for the DESim VGA port. A start pulse in IDLE latches a
//  rectangle, colour and mode; the engine then walks the clipped area in
//  raster order (x fastest), one coordinate per clock.
//  Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : slave side of vga_rect_plotter_if
//              (start/mode/x0/y0/w/h/color in; busy/done, VGA_X/VGA_Y/
//               VGA_COLOR/plot out; pixel outputs are registered)
module vga_rect_plotter
    import vga_rect_plotter_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset,
    vga_rect_plotter_if.slave bus
);

    localparam logic [X_W:0] X_ONE = 1;
    localparam logic [Y_W:0] Y_ONE = 1;

    state_e         state, state_nxt;
    mode_e          mode_r, mode_nxt;
    logic [C_W-1:0] color_r, color_nxt;
    logic [X_W-1:0] xs_r, xs_nxt;
    logic [Y_W-1:0] ys_r, ys_nxt;
    logic [X_W:0]   xe_r, xe_nxt;
    logic [Y_W:0]   ye_r, ye_nxt;
    logic [X_W:0]   xl_r, xl_nxt;
    logic [Y_W:0]   yl_r, yl_nxt;
    logic [X_W-1:0] cx, cx_nxt;
    logic [Y_W-1:0] cy, cy_nxt;
    logic [X_W-1:0] vga_x_r, vga_x_nxt;
    logic [Y_W-1:0] vga_y_r, vga_y_nxt;
    logic [C_W-1:0] vga_c_r, vga_c_nxt;
    logic           plot_r, plot_nxt;

    logic [X_W-1:0] c_xs;
    logic [Y_W-1:0] c_ys;
    logic [X_W:0]   c_xe;
    logic [Y_W:0]   c_ye;
    logic           c_empty;

    vga_rect_clip u_clip (
        .mode  (mode_e'(bus.mode)),
        .x0    (bus.x0),
        .y0    (bus.y0),
        .w     (bus.w),
        .h     (bus.h),
        .xs    (c_xs),
        .ys    (c_ys),
        .xe    (c_xe),
        .ye    (c_ye),
        .empty (c_empty)
    );

    // Next-state and next-pixel logic. The first pixel is loaded into the
    // output registers on the accept edge, so it is visible one cycle after
    // start. In DRAW the counters always hold the pixel currently on the
    // outputs; once that is the last cell of the area we move to DONE.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        color_nxt = color_r;
        xs_nxt    = xs_r;
        ys_nxt    = ys_r;
        xe_nxt    = xe_r;
        ye_nxt    = ye_r;
        xl_nxt    = xl_r;
        yl_nxt    = yl_r;
        cx_nxt    = cx;
        cy_nxt    = cy;
        vga_x_nxt = vga_x_r;
        vga_y_nxt = vga_y_r;
        vga_c_nxt = vga_c_r;
        plot_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mode_nxt  = mode_e'(bus.mode);
                    color_nxt = bus.color;
                    xs_nxt    = c_xs;
                    ys_nxt    = c_ys;
                    xe_nxt    = c_xe;
                    ye_nxt    = c_ye;
                    xl_nxt    = {1'b0, bus.x0} + {1'b0, bus.w} - X_ONE;
                    yl_nxt    = {1'b0, bus.y0} + {1'b0, bus.h} - Y_ONE;
                    if (c_empty) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRAW;
                        cx_nxt    = c_xs;
                        cy_nxt    = c_ys;
                        vga_x_nxt = c_xs;
                        vga_y_nxt = c_ys;
                        vga_c_nxt = bus.color;
                        plot_nxt  = pixel_plot(mode_nxt, c_xs, c_ys, c_xs, c_ys,
                                               xl_nxt, yl_nxt);
                    end
                end
            end

            DRAW: begin
                if ({1'b0, cx} == xe_r - X_ONE) begin
                    if ({1'b0, cy} == ye_r - Y_ONE) begin
                        state_nxt = DONE;
                    end else begin
                        cx_nxt = xs_r;
                        cy_nxt = cy + Y_W'(1);
                    end
                end else begin
                    cx_nxt = cx + X_W'(1);
                end
                if (state_nxt == DRAW) begin
                    vga_x_nxt = cx_nxt;
                    vga_y_nxt = cy_nxt;
                    vga_c_nxt = color_r;
                    plot_nxt  = pixel_plot(mode_r, cx_nxt, cy_nxt, xs_r, ys_r,
                                           xl_r, yl_r);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched request, walk counters and registered pixel port. Reset
    // clears the strobe immediately, so an aborted draw leaves no trailing
    // plot.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_r  <= MODE_FILL;
            color_r <= '0;
            xs_r    <= '0;
            ys_r    <= '0;
            xe_r    <= '0;
            ye_r    <= '0;
            xl_r    <= '0;
            yl_r    <= '0;
            cx      <= '0;
            cy      <= '0;
            vga_x_r <= '0;
            vga_y_r <= '0;
            vga_c_r <= '0;
            plot_r  <= 1'b0;
        end else begin
            mode_r  <= mode_nxt;
            color_r <= color_nxt;
            xs_r    <= xs_nxt;
            ys_r    <= ys_nxt;
            xe_r    <= xe_nxt;
            ye_r    <= ye_nxt;
            xl_r    <= xl_nxt;
            yl_r    <= yl_nxt;
            cx      <= cx_nxt;
            cy      <= cy_nxt;
            vga_x_r <= vga_x_nxt;
            vga_y_r <= vga_y_nxt;
            vga_c_r <= vga_c_nxt;
            plot_r  <= plot_nxt;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.VGA_X     = vga_x_r;
    assign bus.VGA_Y     = vga_y_r;
    assign bus.VGA_COLOR = vga_c_r;
    assign bus.plot      = plot_r;

endmodule
